// File: rtl/uart_tx_configurable.sv
// Configurable UART transmitter.
// Sends a DATA_BITS-wide word as a start bit, the data bits LSB first, an optional
// parity bit and 1 or 2 stop bits. Words are taken over a ready/valid handshake.
// A new word offered in the last cycle of the final stop bit starts the next frame
// immediately, with no idle time on the line between the two frames.
module uart_tx_configurable #(
   parameter int unsigned CLOCK_FREQUENCY = 100000000,
   parameter int unsigned BAUD_RATE       = 10000,
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned PARITY_MODE     = 0,
   parameter int unsigned STOP_BITS       = 1
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int unsigned CYCLES_PER_BIT = (BAUD_RATE == 0) ? 0 : CLOCK_FREQUENCY / BAUD_RATE;
   localparam int unsigned BaudW = (CYCLES_PER_BIT < 2) ? 1 : $clog2(CYCLES_PER_BIT);
   localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

   localparam logic [BaudW-1:0] BaudLast  = BaudW'(CYCLES_PER_BIT - 1);
   localparam logic [BitW-1:0]  DataLast  = BitW'(DATA_BITS - 1);
   localparam logic [BitW-1:0]  StopLast  = BitW'(STOP_BITS - 1);
   localparam bit               HasParity = (PARITY_MODE != 0);
   localparam bit               OddParity = (PARITY_MODE == 1);

   // Parameter legality is checked while elaborating.
   if (BAUD_RATE == 0 || CYCLES_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_configurable: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_configurable: DATA_BITS must be in the range 5..9");
   end
   if (PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_configurable: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_configurable: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                 state_q, state_d;
   logic [BaudW-1:0]       baud_q, baud_d;
   logic [BitW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic                   tx_q, tx_d;

   logic                   bit_end;
   logic                   frame_end;
   logic                   accept;

   // Next-state logic, handshake outputs and the next line level.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = tx_q;

      bit_end   = (baud_q == BaudLast);
      // Last cycle of the last stop bit: the only non-idle cycle that accepts a word.
      frame_end = (state_q == StStop) && bit_end && (bit_q == StopLast);
      o_ready   = (state_q == StIdle) || frame_end;
      o_done    = frame_end;
      o_busy    = (state_q != StIdle);
      accept    = i_valid && o_ready;

      if (state_q != StIdle) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_q == DataLast) begin
                  bit_d = '0;
                  if (HasParity) begin
                     state_d = StParity;
                     tx_d    = parity_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (bit_q == StopLast) begin
                  state_d = StIdle;
                  bit_d   = '0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      // A handshake overrides the idle/return path and launches the start bit.
      if (accept) begin
         state_d  = StStart;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = i_data;
         parity_d = (^i_data) ^ OddParity;
         tx_d     = 1'b0;
      end
   end

   // State registers with synchronous reset; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

   assign o_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_configurable.sv
// Self-checking bench for uart_tx_configurable.
// Four instances cover 8N1, 7E2, 7O2 and 9N1. A frame-level model predicts every
// output on every cycle; literal expectations pin selected frame positions.
module tb_uart_tx_configurable;

   localparam int unsigned ClkFreq  = 1000;
   localparam int unsigned BaudRate = 100;
   localparam int          Cpb      = 10;
   localparam int          NInst    = 4;
   localparam int          HistLen  = 256;

   function automatic int db_of(input int g);
      case (g)
         0:       return 8;
         3:       return 9;
         default: return 7;
      endcase
   endfunction

   function automatic int pm_of(input int g);
      case (g)
         1:       return 2;
         2:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int sb_of(input int g);
      return (g == 1 || g == 2) ? 2 : 1;
   endfunction

   function automatic int flen_of(input int g);
      return (1 + db_of(g) + ((pm_of(g) != 0) ? 1 : 0) + sb_of(g)) * Cpb;
   endfunction

   logic             clk = 1'b0;
   logic [NInst-1:0] rst;
   logic [NInst-1:0] valid;
   logic [NInst-1:0] ready;
   logic [NInst-1:0] tx;
   logic [NInst-1:0] busy;
   logic [NInst-1:0] done;
   logic [8:0]       data [NInst];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NInst; g++) begin : g_dut
      localparam int unsigned Db = db_of(g);
      uart_tx_configurable #(
         .CLOCK_FREQUENCY(ClkFreq),
         .BAUD_RATE      (BaudRate),
         .DATA_BITS      (Db),
         .PARITY_MODE    (pm_of(g)),
         .STOP_BITS      (sb_of(g))
      ) u_dut (
         .clk    (clk),
         .i_reset(rst[g]),
         .i_data (data[g][Db-1:0]),
         .i_valid(valid[g]),
         .o_ready(ready[g]),
         .o_tx   (tx[g]),
         .o_busy (busy[g]),
         .o_done (done[g])
      );
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Frame model: active flag, cycle index within the frame (1..len) and line bits.
   bit          active [NInst];
   int          t      [NInst];
   logic [15:0] frame  [NInst];

   logic h_tx    [HistLen];
   logic h_busy  [HistLen];
   logic h_done  [HistLen];
   logic h_ready [HistLen];

   int a5_line [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] build_frame(input int g, input logic [8:0] d);
      logic [15:0] f;
      logic        p;
      f    = '1;
      p    = 1'b0;
      f[0] = 1'b0;
      for (int i = 0; i < db_of(g); i++) begin
         f[1+i] = d[i];
         p      = p ^ d[i];
      end
      if (pm_of(g) == 2) f[1+db_of(g)] = p;
      if (pm_of(g) == 1) f[1+db_of(g)] = ~p;
      return f;
   endfunction

   task automatic model_step();
      for (int g = 0; g < NInst; g++) begin
         if (rst[g]) begin
            active[g] = 1'b0;
            t[g]      = 0;
         end else if (valid[g] && (!active[g] || t[g] == flen_of(g))) begin
            frame[g]  = build_frame(g, data[g]);
            active[g] = 1'b1;
            t[g]      = 1;
         end else if (active[g]) begin
            if (t[g] == flen_of(g)) begin
               active[g] = 1'b0;
               t[g]      = 0;
            end else begin
               t[g]++;
            end
         end
      end
   endtask

   // One clock: advance the model at the edge, compare every instance mid-cycle.
   task automatic tick();
      logic e_tx, e_busy, e_done, e_ready;
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int g = 0; g < NInst; g++) begin
         e_done  = active[g] && (t[g] == flen_of(g));
         e_tx    = active[g] ? frame[g][(t[g]-1)/Cpb] : 1'b1;
         e_busy  = active[g];
         e_ready = !active[g] || e_done;
         chk($sformatf("i%0d tx t=%0d", g, t[g]), 32'(tx[g]), 32'(e_tx));
         chk($sformatf("i%0d busy t=%0d", g, t[g]), 32'(busy[g]), 32'(e_busy));
         chk($sformatf("i%0d done t=%0d", g, t[g]), 32'(done[g]), 32'(e_done));
         chk($sformatf("i%0d ready t=%0d", g, t[g]), 32'(ready[g]), 32'(e_ready));
      end
   endtask

   // Runs n cycles of instance g, logging outputs; k=1 is the cycle after the first edge.
   task automatic record(input int g, input int n, input int off_at, input logic [8:0] d2,
                         input int pulse_at);
      for (int k = 1; k <= n; k++) begin
         tick();
         h_tx[k]    = tx[g];
         h_busy[k]  = busy[g];
         h_done[k]  = done[g];
         h_ready[k] = ready[g];
         if (k == 1) data[g] = d2;
         if (k == off_at) valid[g] = 1'b0;
         if (pulse_at > 0 && k == pulse_at) begin
            valid[g] = 1'b1;
            data[g]  = 9'h03C;
         end
         if (pulse_at > 0 && k == pulse_at + 1) valid[g] = 1'b0;
      end
   endtask

   task automatic send(input int g, input logic [8:0] d, input int n);
      data[g]  = d;
      valid[g] = 1'b1;
      record(g, n, 1, d, 0);
   endtask

   function automatic int cnt(input logic h [HistLen], input int lo, input int hi);
      int c = 0;
      for (int k = lo; k <= hi; k++) c += (h[k] === 1'b1) ? 1 : 0;
      return c;
   endfunction

   initial begin
      rst   = '1;
      valid = '0;
      for (int g = 0; g < NInst; g++) begin
         data[g]   = '0;
         active[g] = 1'b0;
         t[g]      = 0;
         frame[g]  = '1;
      end
      tick();
      tick();
      rst = '0;
      tick();
      for (int g = 0; g < NInst; g++) begin
         chk($sformatf("reset i%0d tx", g), 32'(tx[g]), 1);
         chk($sformatf("reset i%0d ready", g), 32'(ready[g]), 1);
         chk($sformatf("reset i%0d busy", g), 32'(busy[g]), 0);
         chk($sformatf("reset i%0d done", g), 32'(done[g]), 0);
      end

      // 8N1, 0xA5.
      send(0, 9'h0A5, 105);
      for (int b = 0; b < 10; b++) begin
         chk($sformatf("a5 bit%0d first", b), 32'(h_tx[1+10*b]), 32'(a5_line[b]));
         chk($sformatf("a5 bit%0d last", b), 32'(h_tx[10+10*b]), 32'(a5_line[b]));
      end
      chk("a5 busy cycles", cnt(h_busy, 1, 105), 100);
      chk("a5 done at 100", 32'(h_done[100]), 1);
      chk("a5 done count", cnt(h_done, 1, 105), 1);
      chk("a5 idle at 101", 32'(h_busy[101]), 0);
      chk("a5 ready at 101", 32'(h_ready[101]), 1);

      // 7E2 and 7O2, 0x41.
      send(1, 9'h041, 115);
      chk("7e2 d0", 32'(h_tx[11]), 1);
      chk("7e2 d6", 32'(h_tx[71]), 1);
      chk("7e2 parity", 32'(h_tx[81]), 0);
      chk("7e2 parity end", 32'(h_tx[90]), 0);
      chk("7e2 stop high", cnt(h_tx, 91, 110), 20);
      chk("7e2 done at 110", 32'(h_done[110]), 1);
      chk("7e2 busy cycles", cnt(h_busy, 1, 115), 110);
      send(2, 9'h041, 115);
      chk("7o2 parity", 32'(h_tx[81]), 1);
      chk("7o2 parity end", 32'(h_tx[90]), 1);
      chk("7o2 done at 110", 32'(h_done[110]), 1);

      // Back-to-back 0x00 then 0xFF with valid held.
      data[0]  = 9'h000;
      valid[0] = 1'b1;
      record(0, 205, 101, 9'h0FF, 0);
      chk("b2b first d0", 32'(h_tx[11]), 0);
      chk("b2b first stop", 32'(h_tx[100]), 1);
      chk("b2b first done", 32'(h_done[100]), 1);
      chk("b2b second start", 32'(h_tx[101]), 0);
      chk("b2b busy kept", 32'(h_busy[101]), 1);
      chk("b2b second d0", 32'(h_tx[111]), 1);
      chk("b2b second d7", 32'(h_tx[190]), 1);
      chk("b2b second done", 32'(h_done[200]), 1);
      chk("b2b busy cycles", cnt(h_busy, 1, 205), 200);

      // Reset in cycle 35 of a frame, then a clean frame.
      send(0, 9'h05A, 35);
      chk("pre-reset d2 low", 32'(h_tx[35]), 0);
      rst[0] = 1'b1;
      tick();
      chk("abort tx", 32'(tx[0]), 1);
      chk("abort ready", 32'(ready[0]), 1);
      chk("abort busy", 32'(busy[0]), 0);
      rst[0] = 1'b0;
      tick();
      send(0, 9'h0C3, 105);
      chk("post-reset start", 32'(h_tx[1]), 0);
      chk("post-reset d0", 32'(h_tx[11]), 1);
      chk("post-reset d2", 32'(h_tx[31]), 0);
      chk("post-reset busy cycles", cnt(h_busy, 1, 105), 100);
      chk("post-reset done", 32'(h_done[100]), 1);

      // 0x3C pulsed mid-frame of 0x0F must be ignored.
      data[0]  = 9'h00F;
      valid[0] = 1'b1;
      record(0, 105, 1, 9'h00F, 40);
      chk("ignore ready mid-frame", cnt(h_ready, 1, 99), 0);
      chk("ignore d1", 32'(h_tx[21]), 1);
      chk("ignore d4", 32'(h_tx[51]), 0);
      chk("ignore d5", 32'(h_tx[61]), 0);
      chk("ignore no 2nd frame", cnt(h_busy, 101, 105), 0);

      // 9N1, all ones.
      send(3, 9'h1FF, 115);
      chk("9n1 busy cycles", cnt(h_busy, 1, 115), 110);
      chk("9n1 data ones", cnt(h_tx, 11, 100), 90);
      chk("9n1 stop", 32'(h_tx[101]), 1);
      chk("9n1 done at 110", 32'(h_done[110]), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
